// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uartTx byte transmitter between NUM_REQ requesters.
// Optional message lock (grant held until req_last) is enabled with `define UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ISSUE_TIMEOUT = 1023,
  parameter int MIN_GAP       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_we,
  input  logic                 i_tx_busy,
  output logic                 o_arb_busy,
  output logic                 o_timeout_err,
  input  logic                 i_err_clear
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(ISSUE_TIMEOUT + 1);
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_RELEASE} state_t;

  state_t             r_state;
  logic               r_busy_m, r_busy_s;
  logic [IW-1:0]      r_rr, r_owner, w_pick;
  logic               w_found, w_hold, r_locked;
  logic [TW-1:0]      r_to;
  logic [GW-1:0]      r_gap;
  logic [NUM_REQ-1:0] r_grant, w_ready;
  logic [7:0]         r_tx_data;
  logic               r_tx_we, r_err;

  function automatic logic [IW-1:0] rot(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NUM_REQ);
  endfunction

  // Descending scan so the smallest offset from the rr pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr;
    if (r_locked) begin
      w_found = i_req_valid[r_owner];
      w_pick  = r_owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (i_req_valid[rot(r_rr, k)]) begin
          w_found = 1'b1;
          w_pick  = rot(r_rr, k);
        end
      end
    end
    w_ready = '0;
    if (r_state == S_ARB && w_found) w_ready[w_pick] = 1'b1;
  end

`ifdef UART_ARB_LOCK_EN
  assign w_hold = ~i_req_last[w_pick];
`else
  logic w_unused_last;
  assign w_unused_last = ^i_req_last;
  assign w_hold        = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_busy_m  <= 1'b0;
      r_busy_s  <= 1'b0;
      r_rr      <= '0;
      r_owner   <= '0;
      r_locked  <= 1'b0;
      r_to      <= '0;
      r_gap     <= GW'(MIN_GAP);
      r_grant   <= '0;
      r_tx_data <= 8'h00;
      r_tx_we   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_busy_m <= i_tx_busy;
      r_busy_s <= r_busy_m;
      if (i_err_clear) r_err <= 1'b0;
      case (r_state)
        S_IDLE:
          if (|i_req_valid && r_gap == GW'(MIN_GAP) && !r_busy_s) r_state <= S_ARB;
        S_ARB:
          if (w_found) begin
            r_tx_data <= i_req_data[8*w_pick +: 8];
            r_grant   <= w_ready;
            r_owner   <= w_pick;
            r_locked  <= w_hold;
            r_tx_we   <= 1'b1;
            r_to      <= '0;
            r_state   <= S_ISSUE;
          end else begin
            // A locked owner that withdrew keeps its grant and waits in RELEASE.
            r_state <= r_locked ? S_RELEASE : S_IDLE;
          end
        S_ISSUE:
          if (r_busy_s) begin
            r_tx_we <= 1'b0;
            r_state <= S_WAIT;
          end else if (r_to == TW'(ISSUE_TIMEOUT - 1)) begin
            r_tx_we  <= 1'b0;
            r_err    <= 1'b1;
            r_locked <= 1'b0;
            r_grant  <= '0;
            r_rr     <= rot(r_owner, 1);
            r_state  <= S_IDLE;
          end else begin
            r_to <= r_to + 1'b1;
          end
        S_WAIT:
          if (!r_busy_s) begin
            r_gap   <= '0;
            r_state <= S_RELEASE;
          end
        S_RELEASE:
          if (r_gap != GW'(MIN_GAP)) begin
            r_gap <= r_gap + 1'b1;
          end else if (!r_locked) begin
            r_grant <= '0;
            r_rr    <= rot(r_owner, 1);
            r_state <= S_IDLE;
          end else if (i_req_valid[r_owner]) begin
            r_state <= S_ARB;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready   = w_ready;
  assign o_grant       = r_grant;
  assign o_tx_data     = r_tx_data;
  assign o_tx_we       = r_tx_we;
  assign o_arb_busy    = (r_state != S_IDLE);
  assign o_timeout_err = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand-written multi-cycle sequences,
// with a behavioural uartTx busy model that logs every byte it latches.
module tb_uart_tx_arbiter;
  localparam int NR = 2, TO = 15, GAP = 4;

  logic            clock = 1'b0, reset = 1'b0;
  logic [NR-1:0]   req_valid = '0, req_last = '1, req_ready, grant;
  logic [8*NR-1:0] req_data = '0;
  logic [7:0]      tx_data;
  logic            tx_we, tx_busy, arb_busy, timeout_err, err_clear = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NR), .ISSUE_TIMEOUT(TO), .MIN_GAP(GAP)) dut (
    .clock(clock), .reset(reset), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_grant(grant), .o_tx_data(tx_data),
    .o_tx_we(tx_we), .i_tx_busy(tx_busy), .o_arb_busy(arb_busy),
    .o_timeout_err(timeout_err), .i_err_clear(err_clear));

  always #5 clock = ~clock;

  // uartTx stand-in: latches on we while idle, busy for 10 cycles, shares reset.
  logic          model_en = 1'b1, m_busy;
  int            m_cnt;
  logic [7:0]    log_b[$];
  logic [NR-1:0] log_s[$];
  assign tx_busy = m_busy;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_cnt <= 0;
      log_b.delete(); log_s.delete();
    end else if (model_en && !m_busy && tx_we) begin
      m_busy <= 1'b1; m_cnt <= 10;
      log_b.push_back(tx_data); log_s.push_back(grant);
    end else if (m_busy) begin
      if (m_cnt == 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  int tests = 0, fails = 0;

  // Cycles from tx_busy falling to tx_we rising must be at least MIN_GAP+2.
  logic r_pb = 1'b0;
  int   since = 255;
  always @(posedge clock) begin
    r_pb <= tx_busy;
    if (r_pb && !tx_busy) since <= 1;
    else if (since < 255) since <= since + 1;
  end
  a_gap: assert property (@(posedge clock) disable iff (!reset) $rose(tx_we) |-> since >= GAP + 2)
    else begin
      fails++;
      $display("FAIL gap: tx_we rose %0d cycles after tx_busy fell, need >= %0d", since, GAP + 2);
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(output logic [NR-1:0] r);
    int n = 0;
    r = '0;
    while (req_ready == '0 && n < 300) begin @(negedge clock); n++; end
    if (req_ready == '0) begin
      tests++; fails++;
      $display("FAIL accept_timeout: no req_ready after %0d cycles", n);
    end else begin
      r = req_ready;
      @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (arb_busy && n < 400) begin @(negedge clock); n++; end
    if (arb_busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: arb_busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [7:0]    d0, d1;
    logic [NR-1:0] exp_rdy;
    logic [7:0]    exp_byte;
  } vec_t;
  vec_t vecs[7];

  logic [NR-1:0] r;
  logic [7:0]    exp2_b[6], exp3[3];
  logic [NR-1:0] exp2_s[6];
  int            n0, n1, cnt;

  initial begin
    vecs[0] = '{2'b01, 8'h55, 8'h00, 2'b01, 8'h55};
    vecs[1] = '{2'b11, 8'hA0, 8'hB1, 2'b10, 8'hB1};
    vecs[2] = '{2'b11, 8'hA2, 8'hB3, 2'b01, 8'hA2};
    vecs[3] = '{2'b01, 8'hC4, 8'h00, 2'b01, 8'hC4};
    vecs[4] = '{2'b10, 8'h00, 8'hD5, 2'b10, 8'hD5};
    vecs[5] = '{2'b10, 8'h00, 8'hE6, 2'b10, 8'hE6};
    vecs[6] = '{2'b11, 8'hF7, 8'h08, 2'b01, 8'hF7};
    exp2_b = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    exp2_s = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`ifdef UART_ARB_LOCK_EN
    exp3 = '{8'h41, 8'h42, 8'h5A};
`else
    exp3 = '{8'h41, 8'h5A, 8'h42};
`endif

    // Reset values while reset is held
    repeat (2) @(negedge clock);
    chk("rst_ready_grant", {req_ready, grant}, 0);
    chk("rst_tx", {tx_data, tx_we}, 0);
    chk("rst_busy_err", {arb_busy, timeout_err}, 0);
    reset = 1'b1;
    @(negedge clock);

    // Single-byte vectors, per-byte round robin from rr=0
    for (int v = 0; v < 7; v++) begin
      req_valid = vecs[v].valid;
      req_data  = {vecs[v].d1, vecs[v].d0};
      accept(r);
      chk($sformatf("v%0d_ready", v), r, vecs[v].exp_rdy);
      chk($sformatf("v%0d_grant", v), grant, vecs[v].exp_rdy);
      chk($sformatf("v%0d_tx_data", v), tx_data, vecs[v].exp_byte);
      req_valid = '0;
      wait_idle();
      chk($sformatf("v%0d_sent", v), {24'(log_b.size()), log_b[v]}, {24'(v + 1), vecs[v].exp_byte});
    end

    // Both requesters streaming three bytes each
    do_reset();
    n0 = 0; n1 = 0;
    req_valid = 2'b11; req_data = {8'h20, 8'h10};
    for (int k = 0; k < 6; k++) begin
      accept(r);
      if (r[0]) begin n0++; if (n0 < 3) req_data[7:0]  = 8'h10 + 8'(n0); else req_valid[0] = 1'b0; end
      if (r[1]) begin n1++; if (n1 < 3) req_data[15:8] = 8'h20 + 8'(n1); else req_valid[1] = 1'b0; end
    end
    req_valid = '0;
    wait_idle();
    for (int k = 0; k < 6; k++)
      chk($sformatf("rr_order%0d", k), {log_s[k], log_b[k]}, {exp2_s[k], exp2_b[k]});

    // Two-byte message from req 0 against a waiting req 1
    do_reset();
    req_last = 2'b10; req_valid = 2'b11; req_data = {8'h5A, 8'h41};
    n0 = 0;
    for (int k = 0; k < 3; k++) begin
      accept(r);
      if (r[0]) begin
        if (n0 == 0) begin req_data[7:0] = 8'h42; req_last[0] = 1'b1; end
        else req_valid[0] = 1'b0;
        n0++;
      end
      if (r[1]) req_valid[1] = 1'b0;
    end
    req_valid = '0;
    wait_idle();
    for (int k = 0; k < 3; k++) chk($sformatf("msg_order%0d", k), log_b[k], exp3[k]);
    req_last = '1;

    // tx_busy never rises: ISSUE timeout
    model_en = 1'b0;
    do_reset();
    req_valid = 2'b01; req_data = {8'h00, 8'h99};
    accept(r);
    req_valid = '0;
    cnt = 0;
    while (tx_we && cnt < 100) begin cnt++; @(negedge clock); end
    chk("to_we_cycles", cnt, TO);
    chk("to_err_set", timeout_err, 1);
    chk("to_idle", {arb_busy, grant}, 0);
    repeat (3) @(negedge clock);
    chk("to_err_sticky", timeout_err, 1);
    err_clear = 1'b1; @(negedge clock); err_clear = 1'b0;
    chk("to_err_cleared", timeout_err, 0);

    // Reset while waiting on tx_busy, then a fresh transfer
    model_en = 1'b1;
    do_reset();
    req_valid = 2'b01; req_data = {8'h00, 8'h77};
    accept(r);
    req_valid = '0;
    cnt = 0;
    while (tx_we && cnt < 50) begin cnt++; @(negedge clock); end
    chk("wait_state", {tx_we, tx_busy, arb_busy}, 3'b011);
    reset = 1'b0; #1;
    chk("midrst_outs", {tx_we, grant, timeout_err, arb_busy}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    req_valid = 2'b10; req_data = {8'h3C, 8'h00};
    accept(r);
    chk("post_rst_ready", r, 2'b10);
    req_valid = '0;
    wait_idle();
    chk("post_rst_count", log_b.size(), 1);
    chk("post_rst_byte", {log_s[0], log_b[0]}, {2'b10, 8'h3C});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
